ps2_host_tx: RTL

Host-to-device PS/2 transmitter: sends one command byte (LED set 0xED, reset 0xFF, typematic 0xF3, …) from the core to the attached keyboard over the same open-drain clock/data lines the PS/2 receiver listens on. It sits beside `ps2_intf` in the keyboard path. It performs the request-to-send handshake, shifts data on device-generated clock edges and checks the device ACK. While it is busy, it flags the receiver to ignore line activity.

---
 rtl/ps2_pkg.sv | 30 +++
 rtl/ps2_line_filter.sv | 46 ++++
 rtl/ps2_host_tx.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, default
// timing constants, common keyboard command codes and frame builder.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_SHIFT,
        ST_ACK,
        ST_RELEASE
    } tx_state_t;

    localparam int INHIBIT_CYCLES_DEF = 3000;
    localparam int RTS_CYCLES_DEF     = 16;
    localparam int TIMEOUT_CYCLES_DEF = 400000;
    localparam int FILTER_LEN_DEF     = 8;

    localparam logic [7:0] CMD_SET_LEDS  = 8'hED;
    localparam logic [7:0] CMD_TYPEMATIC = 8'hF3;
    localparam logic [7:0] CMD_ENABLE    = 8'hF4;
    localparam logic [7:0] CMD_RESET     = 8'hFF;
    localparam logic [7:0] RSP_ACK       = 8'hFA;

    // {stop, odd parity, d7..d0}; shifted out LSB first
    function automatic logic [9:0] tx_frame(input logic [7:0] d);
        return {1'b1, ~^d, d};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioner: 2-FF synchronizer plus glitch filter.
// Ports: clk, reset_n (sync, active low), line (async in),
// level (filtered level), fall (1-cycle pulse on filtered 1->0).
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = FILTER_LEN_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic line,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // level flips only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            fall  <= 1'b0;
        end else begin
            sync1 <= line;
            sync2 <= sync1;
            fall  <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                level <= sync2;
                cnt   <= '0;
                fall  <= level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift a
// byte on device clock falls, check ACK, with timeout.
// Ports: clk, reset_n, ps2_clk/ps2_data (line levels), ps2_clk_oe/
// ps2_data_oe (1 = pull low), tx_data/tx_valid/tx_ready (request),
// tx_done/tx_error (1-cycle result), rx_inhibit (busy flag to receiver).
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
    parameter int RTS_CYCLES     = RTS_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int FILTER_LEN     = FILTER_LEN_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       rx_inhibit
);

    tx_state_t   state;
    tx_state_t   state_next;
    logic [9:0]  frame;
    logic [3:0]  bit_cnt;
    logic [18:0] cnt;
    logic        data_drv;
    logic        data_meta;
    logic        data_sync;
    logic        clk_level;
    logic        fall;
    logic        load;
    logic        cnt_clr;
    logic        shift_en;
    logic        timeout;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk     (clk),
        .reset_n (reset_n),
        .line    (ps2_clk),
        .level   (clk_level),
        .fall    (fall)
    );

    // one counter serves inhibit, RTS, and the SHIFT..ACK timeout
    assign timeout    = (cnt == 19'(TIMEOUT_CYCLES));
    assign rx_inhibit = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        load        = 1'b0;
        cnt_clr     = 1'b0;
        shift_en    = 1'b0;
        tx_ready    = 1'b0;
        tx_done     = 1'b0;
        tx_error    = 1'b0;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        unique case (state)
            ST_IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    load       = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (cnt == 19'(INHIBIT_CYCLES - 1)) begin
                    cnt_clr    = 1'b1;
                    state_next = ST_RTS;
                end
            end
            ST_RTS: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
                if (cnt == 19'(RTS_CYCLES - 1)) begin
                    cnt_clr    = 1'b1;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                ps2_data_oe = data_drv;
                if (timeout) begin
                    ps2_data_oe = 1'b0;
                    tx_error    = 1'b1;
                    state_next  = ST_IDLE;
                end else if (fall) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 4'd9) begin
                        state_next = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                if (timeout) begin
                    tx_error   = 1'b1;
                    state_next = ST_IDLE;
                end else if (fall) begin
                    if (data_sync) begin
                        tx_error   = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_RELEASE;
                    end
                end
            end
            ST_RELEASE: begin
                if (clk_level && data_sync) begin
                    tx_done    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_meta <= 1'b1;
            data_sync <= 1'b1;
            frame     <= '0;
            bit_cnt   <= '0;
            cnt       <= '0;
            data_drv  <= 1'b0;
        end else begin
            data_meta <= ps2_data;
            data_sync <= data_meta;
            if (cnt_clr) begin
                cnt <= '0;
            end else if (state != ST_IDLE && state != ST_RELEASE) begin
                cnt <= cnt + 19'd1;
            end
            // data_drv holds the start bit low until the first fall
            if (load) begin
                frame    <= tx_frame(tx_data);
                bit_cnt  <= '0;
                data_drv <= 1'b1;
            end else if (shift_en) begin
                data_drv <= ~frame[bit_cnt];
                bit_cnt  <= bit_cnt + 4'd1;
            end
        end
    end

endmodule
